// File: rtl/board_pkg.sv
// Board-level shared constants: scan-select geometry and default clock division ratios.
package board_pkg;
    localparam int              SCAN_W      = 3;
    localparam int              SCAN_DIGITS = 8;
    localparam logic [7:0]      AN_ALL_OFF  = 8'hFF;
    localparam int              DIV_CPU     = 4;
    localparam int              DIV_SCAN    = 50000;
endpackage

// File: rtl/clk_divider_if.sv
// Signal bundle between the clock divider and its consumers.
// The divider sits on the slave side; whoever drives en and consumes the outputs is the master.
interface clk_divider_if;
    import board_pkg::*;

    logic                   en;
    logic                   clk_n;
    logic                   tick;
    logic [SCAN_W-1:0]      sel_idx;
    logic [SCAN_DIGITS-1:0] an_n;

    modport master (output en, input clk_n, input tick, input sel_idx, input an_n);
    modport slave  (input en, output clk_n, output tick, output sel_idx, output an_n);
endinterface

// File: rtl/sel_decoder_3to8n.sv
// Pure combinational 3-bit index to 8-bit active-low one-hot digit select.
module sel_decoder_3to8n
    import board_pkg::*;
(
    input  logic [SCAN_W-1:0]      i_idx,
    output logic [SCAN_DIGITS-1:0] o_an_n
);
    for (genvar gi = 0; gi < SCAN_DIGITS; gi++) begin : g_digit
        assign o_an_n[gi] = (i_idx == SCAN_W'(gi)) ? 1'b0 : 1'b1;
    end
endmodule

// File: rtl/clk_divider.sv
// Divide-by-N clock with 50% duty (longer low phase for odd N) and an end-of-period tick.
// Define SCAN_SEL_EN to build the seven-segment scan index and its active-low digit select.
module clk_divider
    import board_pkg::*;
#(
    parameter int N = DIV_CPU
) (
    input  logic          clk,
    input  logic          rst,
    clk_divider_if.slave  bus
);
    localparam int CW = $clog2(N);
    localparam int L  = N - N / 2;

    if (N < 2) begin : g_bad_n
        $error("clk_divider: N must be at least 2");
    end

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          w_last;
    logic          r_clk_n;
    logic          r_tick;

    assign w_last     = (r_cnt == CW'(N - 1));
    assign w_cnt_next = w_last ? '0 : r_cnt + 1'b1;

    // Outputs are computed from the next phase so they stay aligned with r_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_clk_n <= 1'b0;
            r_tick  <= 1'b0;
        end else if (bus.en) begin
            r_cnt   <= w_cnt_next;
            r_clk_n <= (w_cnt_next >= CW'(L));
            r_tick  <= (w_cnt_next == CW'(N - 1));
        end
    end

    assign bus.clk_n = r_clk_n;
    assign bus.tick  = r_tick;

`ifdef SCAN_SEL_EN
    logic [SCAN_W-1:0]      r_sel_idx;
    logic [SCAN_DIGITS-1:0] w_an_n;

    // Advances on the same edge that wraps the phase, i.e. one step per tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_idx <= '0;
        end else if (bus.en && w_last) begin
            r_sel_idx <= r_sel_idx + 1'b1;
        end
    end

    sel_decoder_3to8n u_dec (
        .i_idx  (r_sel_idx),
        .o_an_n (w_an_n)
    );

    assign bus.sel_idx = r_sel_idx;
    assign bus.an_n    = w_an_n;
`else
    assign bus.sel_idx = '0;
    assign bus.an_n    = AN_ALL_OFF;
`endif

endmodule

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider at N=4, N=5 and N=2 against an edge-count reference model.
module tb_clk_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clk_divider_if if4 ();
    clk_divider_if if5 ();
    clk_divider_if if2 ();

    clk_divider #(.N(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
    clk_divider #(.N(5)) u5 (.clk(clk), .rst(rst), .bus(if5));
    clk_divider #(.N(2)) u2 (.clk(clk), .rst(rst), .bus(if2));

    // Packed view of every output: {clk_n, tick, sel_idx, an_n}
    wire [12:0] o4 = {if4.clk_n, if4.tick, if4.sel_idx, if4.an_n};
    wire [12:0] o5 = {if5.clk_n, if5.tick, if5.sel_idx, if5.an_n};
    wire [12:0] o2 = {if2.clk_n, if2.tick, if2.sel_idx, if2.an_n};

`ifdef SCAN_SEL_EN
    localparam logic [12:0] RST_OUT = {1'b0, 1'b0, 3'd0, 8'hFE};
`else
    localparam logic [12:0] RST_OUT = {1'b0, 1'b0, 3'd0, 8'hFF};
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: number of enabled edges since the last reset.
    int k4 = 0;
    int k5 = 0;
    int k2 = 0;
    always @(posedge clk) begin
        if (rst) begin
            k4 <= 0;
            k5 <= 0;
            k2 <= 0;
        end else begin
            if (if4.en) k4 <= k4 + 1;
            if (if5.en) k5 <= k5 + 1;
            if (if2.en) k2 <= k2 + 1;
        end
    end

    // Expected outputs after k enabled edges of a divide-by-n counter.
    function automatic logic [12:0] exp_out(input int k, input int n);
        int         ph;
        logic       e_clk;
        logic       e_tick;
        logic [2:0] e_sel;
        logic [7:0] e_an;
        ph     = k % n;
        e_clk  = (ph >= (n - n / 2));
        e_tick = (ph == n - 1);
`ifdef SCAN_SEL_EN
        e_sel  = 3'((k / n) % 8);
        e_an   = 8'hFF ^ (8'h01 << e_sel);
`else
        e_sel  = 3'd0;
        e_an   = 8'hFF;
`endif
        return {e_clk, e_tick, e_sel, e_an};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if4.en = 1'b1; if5.en = 1'b1; if2.en = 1'b1;
        repeat (2) step();
        n_checks++;
        if (o4 !== RST_OUT) $display("FAIL reset_n4: got %h expected %h", o4, RST_OUT);
        else n_pass++;
        n_checks++;
        if (o5 !== RST_OUT) $display("FAIL reset_n5: got %h expected %h", o5, RST_OUT);
        else n_pass++;
        n_checks++;
        if (o2 !== RST_OUT) $display("FAIL reset_n2: got %h expected %h", o2, RST_OUT);
        else n_pass++;
        $display("reset held 2 cycles: n4=%h n5=%h n2=%h", o4, o5, o2);
    endtask

    task automatic test_n4_sequence();
        logic [12:0] e;
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            e = exp_out(k4, 4);
            n_checks++;
            if (o4 !== e) $display("FAIL n4_seq edge %0d: got %h expected %h", i, o4, e);
            else n_pass++;
            $display("n4 edge %0d: clk_n=%b tick=%b sel=%0d an=%h", i, if4.clk_n, if4.tick, if4.sel_idx, if4.an_n);
        end
    endtask

    task automatic test_n5_duty();
        logic [12:0] e;
        int hi;
        int tk;
        hi = 0;
        tk = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            e = exp_out(k5, 5);
            n_checks++;
            if (o5 !== e) $display("FAIL n5_seq k=%0d: got %h expected %h", k5, o5, e);
            else n_pass++;
            if (if5.clk_n === 1'b1) hi++;
            if (if5.tick === 1'b1) tk++;
            $display("n5 k=%0d: clk_n=%b tick=%b", k5, if5.clk_n, if5.tick);
        end
        n_checks++;
        if (hi != 4) $display("FAIL n5_high_cycles: got %0d expected 4", hi);
        else n_pass++;
        n_checks++;
        if (tk != 2) $display("FAIL n5_tick_count: got %0d expected 2", tk);
        else n_pass++;
    endtask

    task automatic test_scan();
        logic [12:0] e;
        for (int i = 0; i < 20; i++) begin
            step();
            e = exp_out(k2, 2);
            n_checks++;
            if (o2 !== e) $display("FAIL scan_n2 k=%0d: got %h expected %h", k2, o2, e);
            else n_pass++;
            $display("n2 k=%0d: sel=%0d an=%h tick=%b", k2, if2.sel_idx, if2.an_n, if2.tick);
        end
    endtask

    task automatic test_enable_hold();
        logic [12:0] e;
        int guard;
        guard = 0;
        while (k4 % 4 != 2 && guard < 8) begin
            step();
            guard++;
        end
        n_checks++;
        if (k4 % 4 != 2) $display("FAIL hold_setup: phase %0d expected 2", k4 % 4);
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            if4.en = (i >= 3);
            step();
            e = exp_out(k4, 4);
            n_checks++;
            if (o4 !== e) $display("FAIL hold_n4 step %0d en=%b: got %h expected %h", i, if4.en, o4, e);
            else n_pass++;
            $display("hold step %0d en=%b: clk_n=%b tick=%b sel=%0d", i, if4.en, if4.clk_n, if4.tick, if4.sel_idx);
        end
        if4.en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while (k4 % 4 != 3 && guard < 8) begin
            step();
            guard++;
        end
        n_checks++;
        if (if4.tick !== 1'b1) $display("FAIL mid_tick_before_rst: got %b expected 1", if4.tick);
        else n_pass++;
        rst = 1'b1;
        step();
        n_checks++;
        if (o4 !== RST_OUT) $display("FAIL mid_reset_n4: got %h expected %h", o4, RST_OUT);
        else n_pass++;
        n_checks++;
        if (o5 !== RST_OUT) $display("FAIL mid_reset_n5: got %h expected %h", o5, RST_OUT);
        else n_pass++;
        $display("reset at phase 3: n4=%h n5=%h", o4, o5);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [12:0] e4, e5, e2;
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 49) == 0);
            if4.en = ($urandom_range(0, 3) != 0);
            if5.en = ($urandom_range(0, 3) != 0);
            if2.en = ($urandom_range(0, 1) != 0);
            step();
            e4 = exp_out(k4, 4);
            e5 = exp_out(k5, 5);
            e2 = exp_out(k2, 2);
            n_checks++;
            if (o4 !== e4) $display("FAIL rand_n4 cyc %0d: got %h expected %h", i, o4, e4);
            else n_pass++;
            n_checks++;
            if (o5 !== e5) $display("FAIL rand_n5 cyc %0d: got %h expected %h", i, o5, e5);
            else n_pass++;
            n_checks++;
            if (o2 !== e2) $display("FAIL rand_n2 cyc %0d: got %h expected %h", i, o2, e2);
            else n_pass++;
            $display("rand cyc %0d rst=%b: n4=%h n5=%h n2=%h", i, rst, o4, o5, o2);
        end
        rst = 1'b0;
    endtask

    initial begin
        if4.en = 1'b0;
        if5.en = 1'b0;
        if2.en = 1'b0;
        test_reset();
        test_n4_sequence();
        test_n5_duty();
        test_scan();
        test_enable_hold();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
